// File: rtl/cache_mem_responder.sv
// -----------------------------------------------------------------------------
// cache_mem_responder
//
// Simulation memory model for the far end of the cache refill/writeback path.
// The cache is the initiator: it issues reads (byte/half/word as one beat, or
// a full 16-byte line as four beats) and writes (byte-masked word or full
// line). Reads return data after RD_LAT idle cycles; writes commit to the word
// array after WR_LAT+1 cycles. Only one request is in flight at a time.
//
// Ports
//   clk_i, reset_i            clock, asynchronous active-high reset
//   rd_req_i/rd_type_i/rd_addr_i, rd_rdy_o
//                             read request channel (type 100 = line)
//   ret_valid_o/ret_last_o/ret_data_o
//                             read return beats, no backpressure
//   wr_req_i/wr_type_i/wr_addr_i/wr_wstrb_i/wr_data_i, wr_rdy_o
//                             write request channel (type 100 = line)
//   err_o                     sticky: a line request had addr[3:0] != 0
//
// The word array holds mem[i] = i from time zero and is not touched by reset.
// Address bits above ADDR_W+1 are ignored, so the address space aliases.
// -----------------------------------------------------------------------------
module cache_mem_responder #(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         rd_req_i,
    input  logic [2:0]   rd_type_i,
    input  logic [31:0]  rd_addr_i,
    output logic         rd_rdy_o,
    output logic         ret_valid_o,
    output logic         ret_last_o,
    output logic [31:0]  ret_data_o,
    input  logic         wr_req_i,
    input  logic [2:0]   wr_type_i,
    input  logic [31:0]  wr_addr_i,
    input  logic [3:0]   wr_wstrb_i,
    input  logic [127:0] wr_data_i,
    output logic         wr_rdy_o,
    output logic         err_o
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [2:0] TYPE_LINE = 3'b100;
    // The latency counter counts down to zero; a read spends RD_LAT cycles in
    // RD_WAIT, a write spends WR_LAT+1 cycles in WR_WAIT.
    localparam logic [3:0] RD_LAT_M1 = (RD_LAT == 0) ? 4'd0 : 4'(RD_LAT - 1);
    localparam logic [3:0] WR_LAT_C  = 4'(WR_LAT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_RD_BEAT = 2'd2,
        S_WR_WAIT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          lat_q, lat_d;
    logic [1:0]          beat_q, beat_d;
    logic                line_q, line_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [127:0]        wdata_q, wdata_d;
    logic                err_q, err_d;

    logic                rd_is_line;
    logic                wr_is_line;
    logic [ADDR_W-1:0]   rd_word_idx;
    logic [ADDR_W-1:0]   wr_word_idx;
    logic                last_beat;
    logic                commit;
    logic                beat_active;
    logic [ADDR_W-1:0]   rd_idx;
    logic [31:0]         mem_rd [DEPTH];

    assign rd_is_line  = (rd_type_i == TYPE_LINE);
    assign wr_is_line  = (wr_type_i == TYPE_LINE);
    assign rd_word_idx = rd_addr_i[ADDR_W+1:2];
    assign wr_word_idx = wr_addr_i[ADDR_W+1:2];

    // Non-line reads are a single beat, so beat 0 is always the last one.
    assign last_beat = !line_q || (beat_q == 2'd3);
    assign commit    = (state_q == S_WR_WAIT) && (lat_q == 4'd0);
    // Line bases are aligned, so the beat number simply fills the low bits.
    assign rd_idx    = line_q ? {base_q[ADDR_W-1:2], beat_q} : base_q;

    // Address bits that only select aliased copies of the array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{rd_addr_i[31:ADDR_W+2], wr_addr_i[31:ADDR_W+2]};

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            lat_q   <= 4'd0;
            beat_q  <= 2'd0;
            line_q  <= 1'b0;
            base_q  <= '0;
            wstrb_q <= 4'd0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            base_q  <= base_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        line_d  = line_q;
        base_d  = base_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                // A write wins over a simultaneous read; the read stays
                // pending on the bus until the write has committed.
                if (wr_req_i) begin
                    state_d = S_WR_WAIT;
                    lat_d   = WR_LAT_C;
                    line_d  = wr_is_line;
                    base_d  = wr_is_line ? {wr_word_idx[ADDR_W-1:2], 2'b00}
                                         : wr_word_idx;
                    wstrb_d = wr_wstrb_i;
                    wdata_d = wr_data_i;
                    if (wr_is_line && (wr_addr_i[3:0] != 4'h0)) begin
                        err_d = 1'b1;
                    end
                end else if (rd_req_i) begin
                    state_d = (RD_LAT == 0) ? S_RD_BEAT : S_RD_WAIT;
                    lat_d   = RD_LAT_M1;
                    beat_d  = 2'd0;
                    line_d  = rd_is_line;
                    base_d  = rd_is_line ? {rd_word_idx[ADDR_W-1:2], 2'b00}
                                         : rd_word_idx;
                    if (rd_is_line && (rd_addr_i[3:0] != 4'h0)) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RD_WAIT: begin
                if (lat_q == 4'd0) begin
                    state_d = S_RD_BEAT;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            S_RD_BEAT: begin
                beat_d = beat_q + 2'd1;
                if (last_beat) begin
                    state_d = S_IDLE;
                    beat_d  = 2'd0;
                end
            end
            S_WR_WAIT: begin
                if (lat_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        beat_active = (state_q == S_RD_BEAT);
        rd_rdy_o    = (state_q == S_IDLE);
        wr_rdy_o    = (state_q == S_IDLE);
        ret_valid_o = beat_active;
        ret_last_o  = beat_active && last_beat;
        ret_data_o  = beat_active ? mem_rd[rd_idx] : 32'd0;
        err_o       = err_q;
    end

    // ----------------------------------------------------------- word array
    // One register per word so each can carry its own power-up value (its
    // index). It has no reset: contents survive reset, and since reset forces
    // the FSM to IDLE asynchronously, a pending write can never commit.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        localparam logic [ADDR_W-1:0] IDX  = ADDR_W'(gi);
        localparam int                LANE = gi % 4;

        logic [31:0] word_q = 32'(gi);
        logic        hit_line;
        logic        hit_word;

        assign hit_line = commit && line_q
                          && (base_q[ADDR_W-1:2] == IDX[ADDR_W-1:2]);
        assign hit_word = commit && !line_q && (base_q == IDX);

        always_ff @(posedge clk_i) begin
            if (hit_line) begin
                word_q <= wdata_q[32*LANE +: 32];
            end else if (hit_word) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb_q[b]) begin
                        word_q[8*b +: 8] <= wdata_q[8*b +: 8];
                    end
                end
            end
        end

        assign mem_rd[gi] = word_q;
    end

endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
- Simulation memory responder that forms the far end of the cache's refill/writeback interface.
- The cache under test is the initiator. This block accepts its read requests (single word or full 16-byte line) and its write requests (masked word or full line).
- It returns read data as beats after a programmable latency and commits writes to an internal word array.
- It sits beside the cache inside the cache test top and replaces the AXI/SRAM path for standalone cache verification.

Parameters:
- ADDR_W, 10: word-index width; the memory holds 2^ADDR_W 32-bit words. Upper address bits are ignored, so addresses alias.
- RD_LAT, 2: idle cycles between read acceptance and the first ret_valid beat; legal range 0..15.
- WR_LAT, 1: idle cycles between write acceptance and commit; legal range 0..15.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rd_req  in  1  read request valid
- rd_type  in  3  000 byte, 001 half, 010 word, 100 line; any other value is treated as word
- rd_addr  in  32  read byte address
- rd_rdy  out  1  read request accepted this cycle when rd_req && rd_rdy
- ret_valid  out  1  return beat valid; no backpressure
- ret_last  out  1  final beat of the current read
- ret_data  out  32  return data
- wr_req  in  1  write request valid
- wr_type  in  3  100 line; any other value is a word write
- wr_addr  in  32  write byte address
- wr_wstrb  in  4  byte enables; used for word writes only
- wr_data  in  128  line data; word k = wr_data[32k+31:32k]; a word write uses bits [31:0]
- wr_rdy  out  1  write request accepted this cycle when wr_req && wr_rdy
- err  out  1  sticky flag: a line request had a nonzero addr[3:0]

Behaviour:
- Memory contents:
  - Initialised at time zero to mem[i] = i (word index).
  - Contents are NOT cleared by reset.
  - Index = addr[ADDR_W+1:2].
- Reset values:
  - State IDLE.
  - rd_rdy=1, wr_rdy=1.
  - ret_valid=0, ret_last=0, ret_data=0, err=0.
  - Beat and latency counters = 0.
- States:
  - IDLE: rd_rdy = wr_rdy = 1. If wr_req is high, accept the write and go to WR_WAIT; this takes priority over a simultaneous rd_req. Otherwise, if rd_req is high, accept the read and go to RD_WAIT, or directly to RD_BEAT when RD_LAT=0.
  - RD_WAIT: lasts RD_LAT cycles, counted down by the latency counter, then goes to RD_BEAT.
  - RD_BEAT:
    - ret_valid=1 for N consecutive cycles: N=4 for line reads, N=1 otherwise.
    - Beat k returns mem[base+k], where base = the line-aligned word index for line reads, or the word index for other reads.
    - ret_last=1 on beat N-1 only; the state returns to IDLE after that beat.
    - Byte and half reads return the full aligned word.
  - WR_WAIT:
    - Lasts WR_LAT+1 cycles.
    - On the edge that ends the final cycle, the write is committed and the state returns to IDLE.
    - Line write: 4 full words at base+0..3.
    - Word write: bytes of mem[idx] selected by wr_wstrb are replaced.
- Request capture:
  - Address, type, strobe and data are latched at acceptance.
  - Inputs are don't-care after acceptance until the state is IDLE again.
- Timing:
  - rd_rdy and wr_rdy are both 0 in every non-IDLE state.
  - For a read accepted on edge T, the first ret_valid is in cycle T+1+RD_LAT.
  - Back-to-back requests: a new request can be accepted in the first IDLE cycle after ret_last or after a write commit.
- ret_data is 0 whenever ret_valid=0.
- Unaligned line request (rd_addr[3:0]!=0 or wr_addr[3:0]!=0 with type 100):
  - err is set and held until reset.
  - The access proceeds on the aligned line.
- Reset mid-operation:
  - Outputs go to their reset values immediately.
  - Any pending write is dropped; no partial commit occurs.
  - Any remaining beats are not issued.

Test Plan:
- Reset, then line read at 0x040 accepted at edge T → ret_valid in cycles T+3..T+6 with data 0x10, 0x11, 0x12, 0x13; ret_last only in T+6; rd_rdy=0 in T+1..T+6.
- Word write to 0x040, wstrb=0011, wr_data[31:0]=0xDEADBEEF, then word read of 0x040 → one beat of 0x0000BEEF with ret_last=1; err stays 0.
- Line write to 0x080, wr_data=0x44444444_33333333_22222222_11111111, then line read of 0x080 → 0x11111111, 0x22222222, 0x33333333, 0x44444444.
- rd_req and wr_req raised in the same IDLE cycle to line 0x0C0 → write accepted first and rd_rdy stays 0 until commit; the read is then accepted and returns the written data.
- Reset asserted after beat 1 of a line read → ret_valid drops to 0 immediately, with no further beats after release and rd_rdy=1. Reset during WR_WAIT → a subsequent read returns the old word.
- With ADDR_W=10, a line read at 0x1044 → err=1, and data equals that of line 0x040 (aliasing plus alignment); err remains 1 until reset.
